// File: rtl/soc_system_leds_sequencer.sv
// LED pattern sequencer and write arbiter placed in front of the LED PIO s1 port.
// It steps through a pattern table on a timer and forwards host writes when idle.
//   state | meaning
//   IDLE  | no sequence running; direct host writes pass to the PIO
//   LOAD  | write PATTERN[idx] to the PIO, reload the step timer
//   WAIT  | step timer counts down to terminal count
module soc_system_leds_sequencer #(
  parameter int PERIOD_W  = 24,
  parameter int NUM_STEPS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        busy
);

  localparam int IDX_W = $clog2(NUM_STEPS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [PERIOD_W-1:0]  cnt;
  logic                 ctrl_en, ctrl_loop;
  logic [PERIOD_W-1:0]  period;
  logic [IDX_W-1:0]     length;
  logic [7:0]           shadow;
  logic [7:0]           pattern [NUM_STEPS];
  logic                 done, drop;

  logic host_wr, wr_ctrl, wr_period, wr_length, wr_direct, wr_status, wr_pattern;
  logic start, abort, cnt_zero, last_step;
  logic seq_wr, dir_wr, dir_drop, step_adv, seq_done;
  logic unused_bits;

  assign host_wr    = s_chipselect & ~s_write_n;
  assign wr_ctrl    = host_wr && (s_address == 4'd0);
  assign wr_period  = host_wr && (s_address == 4'd1);
  assign wr_length  = host_wr && (s_address == 4'd2);
  assign wr_direct  = host_wr && (s_address == 4'd3);
  assign wr_status  = host_wr && (s_address == 4'd4);
  assign wr_pattern = host_wr && s_address[3];
  assign start      = wr_ctrl && s_writedata[0];
  assign abort      = wr_ctrl && !s_writedata[0];
  assign cnt_zero   = (cnt == '0);
  assign last_step  = (idx == length);
  assign m_address  = 2'b00;
  assign unused_bits = ^s_writedata[31:PERIOD_W];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: state_nxt = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort)
          state_nxt = S_IDLE;
        else if (cnt_zero)
          state_nxt = (!last_step || ctrl_loop) ? S_LOAD : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // An abort landing in LOAD suppresses that step's PIO write as well.
  always_comb begin
    busy     = (state != S_IDLE);
    seq_wr   = (state == S_LOAD) && !abort;
    dir_wr   = wr_direct && (state == S_IDLE);
    dir_drop = wr_direct && (state != S_IDLE);
    step_adv = (state == S_WAIT) && !abort && cnt_zero;
    seq_done = step_adv && last_step && !ctrl_loop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en      <= 1'b0;
      ctrl_loop    <= 1'b0;
      period       <= '0;
      length       <= '0;
      idx          <= '0;
      cnt          <= '0;
      shadow       <= 8'hFF;
      done         <= 1'b0;
      drop         <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en   <= s_writedata[0];
        ctrl_loop <= s_writedata[1];
      end else if (seq_done) begin
        ctrl_en <= 1'b0;
      end
      if (wr_period)  period <= s_writedata[PERIOD_W-1:0];
      if (wr_length)  length <= s_writedata[IDX_W-1:0];
      if (wr_pattern) pattern[s_address[2:0]] <= s_writedata[7:0];

      if (start && (state == S_IDLE))
        idx <= '0;
      else if (step_adv) begin
        if (!last_step)     idx <= idx + IDX_W'(1);
        else if (ctrl_loop) idx <= '0;
      end

      if (seq_wr)
        cnt <= period;
      else if ((state == S_WAIT) && !cnt_zero)
        cnt <= cnt - PERIOD_W'(1);

      if (seq_wr)      shadow <= pattern[idx];
      else if (dir_wr) shadow <= s_writedata[7:0];

      m_chipselect <= seq_wr | dir_wr;
      m_write_n    <= ~(seq_wr | dir_wr);
      if (seq_wr)      m_writedata <= {24'b0, pattern[idx]};
      else if (dir_wr) m_writedata <= {24'b0, s_writedata[7:0]};

      // Set wins over a same-cycle clear so no event is lost.
      if (seq_done) done <= 1'b1;
      else if (wr_status && s_writedata[8]) done <= 1'b0;
      if (dir_drop) drop <= 1'b1;
      else if (wr_status && s_writedata[9]) drop <= 1'b0;
    end
  end

  always_comb begin
    s_readdata = '0;
    if (s_address[3])
      s_readdata = {24'b0, pattern[s_address[2:0]]};
    else begin
      case (s_address[2:0])
        3'd0:    s_readdata = {30'b0, ctrl_loop, ctrl_en};
        3'd1:    s_readdata = {{(32-PERIOD_W){1'b0}}, period};
        3'd2:    s_readdata = {{(32-IDX_W){1'b0}}, length};
        3'd3:    s_readdata = {24'b0, shadow};
        3'd4:    s_readdata = {22'b0, drop, done, 1'b0, idx, 3'b000, busy};
        default: s_readdata = '0;
      endcase
    end
  end

endmodule

// File: doc/soc_system_leds_sequencer.md
# soc_system_leds_sequencer

Hardware LED pattern sequencer and write arbiter in front of the LED PIO's Avalon-MM slave. It holds an 8-entry pattern table and a programmable step period, then autonomously issues PIO data-register writes to step through the pattern. It also forwards direct host LED writes to the PIO when no sequence is running. It sits between the HPS lightweight bridge (slave side) and the LED PIO s1 port (master side).

## Interface
- `PERIOD_W`, 24, width of the step-period counter and PERIOD register.
- `NUM_STEPS`, 8, pattern table depth; fixed power of two; index width is 3.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `s_address` in 4: host register word address.
- `s_chipselect` in 1: host access select.
- `s_write_n` in 1: host write strobe, active-low.
- `s_writedata` in 32: host write data.
- `s_readdata` out 32: host read data; combinational from `s_address`, zero wait states.
- `m_address` out 2: PIO address; always 0 (data register).
- `m_chipselect` out 1: PIO select; registered.
- `m_write_n` out 1: PIO write strobe, active-low; registered.
- `m_writedata` out 32: PIO write data, `{24'b0, value[7:0]}`; registered.
- `busy` out 1: high while the FSM is not IDLE.

## Operation
Register map. A write is `s_chipselect & ~s_write_n`. Unlisted addresses read 0 and ignore writes.
- 0 CTRL: bit0 EN, bit1 LOOP. Reads return stored bits.
- 1 PERIOD: bits[PERIOD_W-1:0].
- 2 LENGTH: bits[2:0] = last step index (steps = LENGTH+1).
- 3 DIRECT:
  - Write: request a PIO write of bits[7:0].
  - Read: SHADOW, the last value written to the PIO.
- 4 STATUS:
  - bit0 running (= `busy`).
  - bits[6:4] current step index.
  - bit8 DONE, sticky.
  - bit9 DROP, sticky.
  - Writing 1 to bit8 or bit9 clears that bit.
- 8..15 PATTERN[0..7]: bits[7:0].

FSM states are IDLE, LOAD and WAIT.
- IDLE: a CTRL write with bit0=1 sets idx=0 and moves to LOAD next cycle.
- LOAD (1 cycle):
  - Next edge drives `m_chipselect=1`, `m_write_n=0`, `m_writedata=PATTERN[idx]`.
  - Sets SHADOW to PATTERN[idx].
  - Loads cnt with PERIOD.
  - Moves to WAIT.
- WAIT: cnt decrements each cycle. When cnt==0:
  - If idx!=LENGTH: idx+1, go to LOAD.
  - Else if LOOP=1: idx=0, go to LOAD.
  - Else: go to IDLE, set DONE, clear EN.
- A CTRL write with bit0=0 in LOAD or WAIT moves to IDLE next cycle. No further PIO writes are issued, and the LEDs keep their last value. A CTRL write with bit0=1 while not IDLE only updates LOOP; it does not restart the sequence.
- The LOOP bit is sampled at the end of the last step, so a mid-sequence change applies at that point.

Arbitration:
- A DIRECT write in IDLE issues a PIO write on the next cycle and updates SHADOW.
- A DIRECT write while `busy` is dropped: it sets DROP and does not change SHADOW or the PIO.
- The sequencer always owns the PIO while `busy`. At most one PIO write is issued per cycle.
- A CTRL EN=1 write and a DIRECT write cannot arrive together, because there is one host port.

Other rules:
- PATTERN writes take effect at the next LOAD of that index, including while running.
- LENGTH or PERIOD writes while running are used at the next comparison or load.
- idx wraps 7 to 0 only via LOOP. LENGTH=7 and LOOP=1 cycle through all 8 entries.
- PERIOD=0 is legal and gives the minimum write spacing.

## Timing
- Reset values:
  - FSM IDLE; idx 0; cnt 0.
  - CTRL, PERIOD, LENGTH, PATTERN, DONE, DROP all 0.
  - SHADOW 0xFF, matching the PIO reset value.
  - `m_chipselect=0`, `m_write_n=1`, `m_address=0`, `m_writedata=0`, `busy=0`.
- Reset issues no PIO write. A reset mid-sequence forces IDLE at the next edge, and any in-flight PIO write strobe deasserts on that edge.
- PIO strobes (`m_chipselect`, `m_write_n` low) are exactly 1 cycle wide. The PIO has no waitrequest, so each write completes in that cycle.
- Latency from the CTRL EN write edge to the first PIO strobe: 2 cycles.
- Spacing between successive sequencer strobes: exactly PERIOD+2 cycles.
- Latency from a DIRECT write edge to the PIO strobe: 1 cycle.
- `busy` rises 1 cycle after the EN write. It falls in the cycle after the final WAIT cnt==0.

## Test plan
- Reset check: assert `reset` for 2 cycles → all outputs equal their reset values; DIRECT read = 0xFF; no PIO strobe at any point.
- Idle direct write: in IDLE, write DIRECT=0x5A → exactly one strobe with `m_writedata`=0x0000005A one cycle later; DIRECT reads 0x5A.
- One-shot sequence: PATTERN[0..2]=0x01,0x02,0x04, LENGTH=2, PERIOD=3, CTRL=0x1 → three strobes carrying 0x01, 0x02, 0x04, 5 cycles apart; then DONE=1, EN=0, `busy`=0.
- Loop wrap with PERIOD=0: LENGTH=7, LOOP=1, PERIOD=0 → strobes every 2 cycles with values PATTERN[0..7],PATTERN[0],…; STATUS idx wraps 7→0.
- Contention: DIRECT=0xAA written while `busy` → no 0xAA strobe, DROP=1, SHADOW unchanged; writing STATUS=0x200 clears DROP.
- Abort mid-operation: CTRL=0 written during WAIT → IDLE next cycle, no further strobes. Separately, `reset` asserted during LOAD → no strobe follows and the FSM is in IDLE.
